// File: rtl/gb_cpu_common_pkg.sv
// Shared types for the gameboy CPU core: sequencer state, control word layout, default words.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package gb_cpu_common_pkg;

  // Sequencer top-level phase.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_ISR   = 2'd2,
    S_HALT  = 2'd3
  } seq_state_t;

  localparam int CTRL_SIG_W = 64;

  // Datapath control fields carried in one packed control word (64 bits total).
  typedef struct packed {
    logic [7:0] alu_op;
    logic [7:0] reg_src;
    logic [7:0] reg_dst;
    logic [7:0] addr_sel;
    logic [7:0] mem_op;
    logic [7:0] pc_op;
    logic [7:0] sp_op;
    logic [7:0] misc;
  } control_signals_t;

  function automatic logic [CTRL_SIG_W-1:0] pack_ctrl(input control_signals_t c);
    return c;
  endfunction

  function automatic control_signals_t unpack_ctrl(input logic [CTRL_SIG_W-1:0] w);
    return control_signals_t'(w);
  endfunction

  // All-zero words: the datapath decodes zero fields as "read [PC] into IR, PC+1"
  // for fetch and as a no-op for idle.
  localparam logic [CTRL_SIG_W-1:0] DEFAULT_FETCH_CTRL = '0;
  localparam logic [CTRL_SIG_W-1:0] DEFAULT_IDLE_CTRL  = '0;

endpackage

// File: rtl/gb_cpu_ctrl_mux.sv
// Selects one control word out of a flattened array by index; out-of-range index yields zero.
// Latency: combinational.
// Backpressure: none.
// Ports: words (N_ENTRIES*CTRL_W flattened, entry i at [i*CTRL_W +: CTRL_W]), sel (index), word (selected).
module gb_cpu_ctrl_mux #(
  parameter int N_ENTRIES = 6,
  parameter int CTRL_W    = 64,
  parameter int IDX_W     = 3
) (
  input  logic [N_ENTRIES*CTRL_W-1:0] words,
  input  logic [IDX_W-1:0]            sel,
  output logic [CTRL_W-1:0]           word
);

  always_comb begin
    word = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (sel == IDX_W'(i)) word = words[i*CTRL_W +: CTRL_W];
    end
  end

endmodule

// File: rtl/gb_cpu_sequencer.sv
// M-cycle sequencer: steps opcode schedules, issues fetch/idle/ISR words, handles prefix, HALT, IRQ.
// Latency: ctrl_next/halted/instr_done combinational from registered state; step/flags registered.
// Backpressure: stall=1 freezes all state so ctrl_next repeats; reset dominates stall.
// Ports: clk, reset (sync, active-high), stall; sched_ctrl/len/prefix/halt and cond_fail from decoder;
//        isr_ctrl dispatch words; irq_pending/irq_enable; ctrl_next, step, prefix_active,
//        isr_active, halted, instr_done to datapath/decoder.
module gb_cpu_sequencer
  import gb_cpu_common_pkg::*;
#(
  parameter int                MAX_M_CYCLES = 6,
  parameter int                CYC_W        = $clog2(MAX_M_CYCLES + 1),
  parameter int                CTRL_W       = 64,
  parameter int                ISR_M_CYCLES = 5,
  parameter logic [CTRL_W-1:0] FETCH_CTRL   = CTRL_W'(DEFAULT_FETCH_CTRL),
  parameter logic [CTRL_W-1:0] IDLE_CTRL    = CTRL_W'(DEFAULT_IDLE_CTRL)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic [MAX_M_CYCLES*CTRL_W-1:0]   sched_ctrl,
  input  logic [CYC_W-1:0]                 sched_len,
  input  logic                             sched_prefix,
  input  logic                             sched_halt,
  input  logic                             cond_fail,
  input  logic [ISR_M_CYCLES*CTRL_W-1:0]   isr_ctrl,
  input  logic                             irq_pending,
  input  logic                             irq_enable,
  output logic [CTRL_W-1:0]                ctrl_next,
  output logic [CYC_W-1:0]                 step,
  output logic                             prefix_active,
  output logic                             isr_active,
  output logic                             halted,
  output logic                             instr_done
);

  seq_state_t        state, state_nxt;
  logic [CYC_W-1:0]  step_nxt;
  logic              prefix_nxt, isr_nxt;

  logic [CTRL_W-1:0] exec_word, isr_word;
  logic [CYC_W-1:0]  len_clamp, len_eff;
  logic              exec_final, isr_final, irq_take;

  gb_cpu_ctrl_mux #(
    .N_ENTRIES (MAX_M_CYCLES),
    .CTRL_W    (CTRL_W),
    .IDX_W     (CYC_W)
  ) u_sched_mux (
    .words (sched_ctrl),
    .sel   (step),
    .word  (exec_word)
  );

  gb_cpu_ctrl_mux #(
    .N_ENTRIES (ISR_M_CYCLES),
    .CTRL_W    (CTRL_W),
    .IDX_W     (CYC_W)
  ) u_isr_mux (
    .words (isr_ctrl),
    .sel   (step),
    .word  (isr_word)
  );

  // Effective length: clamp to MAX_M_CYCLES, and treat zero as a single step so the
  // instruction always completes.
  always_comb begin
    if (sched_len > CYC_W'(MAX_M_CYCLES)) len_clamp = CYC_W'(MAX_M_CYCLES);
    else                                   len_clamp = sched_len;
    len_eff = (len_clamp == '0) ? CYC_W'(1) : len_clamp;
  end

  // >= rather than == keeps step bounded even if the decoder shrinks sched_len mid-instruction.
  assign exec_final = (step >= len_eff - CYC_W'(1)) || cond_fail;
  assign isr_final  = (step == CYC_W'(ISR_M_CYCLES - 1));
  assign irq_take   = irq_pending && irq_enable;

  always_comb begin
    state_nxt  = state;
    step_nxt   = step;
    prefix_nxt = prefix_active;
    isr_nxt    = isr_active;
    ctrl_next  = FETCH_CTRL;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl_next = FETCH_CTRL;
        state_nxt = S_EXEC;
        step_nxt  = '0;
      end
      S_EXEC: begin
        ctrl_next = exec_word;
        if (exec_final) begin
          instr_done = 1'b1;
          step_nxt   = '0;
          // A prefix byte arms the prefixed page; any other final step disarms it.
          prefix_nxt = sched_prefix;
          // Prefix wins over IRQ so dispatch never splits a prefix from its opcode.
          if (sched_prefix)    state_nxt = S_FETCH;
          else if (sched_halt) state_nxt = S_HALT;
          else if (irq_take) begin
            state_nxt = S_ISR;
            isr_nxt   = 1'b1;
          end
          else                 state_nxt = S_FETCH;
        end else begin
          step_nxt = step + CYC_W'(1);
        end
      end
      S_ISR: begin
        ctrl_next = isr_word;
        if (isr_final) begin
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
          step_nxt   = '0;
          isr_nxt    = 1'b0;
        end else begin
          step_nxt = step + CYC_W'(1);
        end
      end
      S_HALT: begin
        ctrl_next = IDLE_CTRL;
        halted    = 1'b1;
        step_nxt  = '0;
        if (irq_pending) begin
          // With IME clear the CPU just wakes and resumes fetching.
          if (irq_enable) begin
            state_nxt = S_ISR;
            isr_nxt   = 1'b1;
          end else begin
            state_nxt = S_FETCH;
          end
        end
      end
      default: begin
        state_nxt = S_FETCH;
        step_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_FETCH;
      step          <= '0;
      prefix_active <= 1'b0;
      isr_active    <= 1'b0;
    end else if (!stall) begin
      state         <= state_nxt;
      step          <= step_nxt;
      prefix_active <= prefix_nxt;
      isr_active    <= isr_nxt;
    end
  end

endmodule
